// File: rtl/wb_retire_queue.sv
// Writeback stage with a DEPTH-entry in-order retire queue, register-file drain and decode forwarding.
// Optional macro WB_DEBUG_TRACE_EN drives the debug_wb_* trace from the retiring head entry.
module wb_retire_queue #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_to_wb_valid,
  input  logic [PC_W-1:0]     mem_pc,
  input  logic [DATA_W/8-1:0] mem_byte_we,
  input  logic [REG_AW-1:0]   mem_dest,
  input  logic [DATA_W-1:0]   mem_result,
  output logic                wb_allowin,
  input  logic                rf_ready,
  output logic [DATA_W/8-1:0] rf_we,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  input  logic [REG_AW-1:0]   rs_a,
  input  logic [REG_AW-1:0]   rs_b,
  output logic                fwd_hit_a,
  output logic                fwd_hit_b,
  output logic [DATA_W-1:0]   fwd_data_a,
  output logic [DATA_W-1:0]   fwd_data_b,
  output logic                wb_stall,
  output logic                wb_empty,
  output logic [PC_W-1:0]     debug_wb_pc,
  output logic [DATA_W/8-1:0] debug_wb_rf_we,
  output logic [REG_AW-1:0]   debug_wb_rf_wnum,
  output logic [DATA_W-1:0]   debug_wb_rf_wdata
);

  localparam int WE_W  = DATA_W / 8;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = PTR_W + 1;

  logic [PC_W-1:0]   pc_q   [DEPTH];
  logic [WE_W-1:0]   we_q   [DEPTH];
  logic [REG_AW-1:0] dest_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push;
  logic pop;
  logic not_empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign not_empty  = (count_q != '0);
  assign pop        = not_empty & rf_ready;
  assign wb_allowin = (count_q < CNT_W'(DEPTH)) | pop;
  assign push       = mem_to_wb_valid & wb_allowin;
  assign wb_empty   = ~not_empty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = ptr_inc(head_q);
    end
    if (push) begin
      tail_d = ptr_inc(tail_q);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail_q]   <= mem_pc;
      we_q[tail_q]   <= (mem_dest == '0) ? '0 : mem_byte_we;
      dest_q[tail_q] <= mem_dest;
      data_q[tail_q] <= mem_result;
    end
  end

  logic [PC_W-1:0]   head_pc;
  logic [WE_W-1:0]   head_we;
  logic [REG_AW-1:0] head_dest;
  logic [DATA_W-1:0] head_data;

  assign head_pc   = not_empty ? pc_q[head_q]   : '0;
  assign head_we   = not_empty ? we_q[head_q]   : '0;
  assign head_dest = not_empty ? dest_q[head_q] : '0;
  assign head_data = not_empty ? data_q[head_q] : '0;

  assign rf_we    = pop ? head_we : '0;
  assign rf_waddr = head_dest;
  assign rf_wdata = head_data;

  // Map each age (0 = oldest) to its physical slot and liveness.
  logic [PTR_W-1:0] age_idx   [DEPTH];
  logic             age_valid [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    logic [SUM_W-1:0] sum;
    assign sum            = {1'b0, head_q} + SUM_W'(gi);
    assign age_idx[gi]    = (sum >= SUM_W'(DEPTH)) ? PTR_W'(sum - SUM_W'(DEPTH)) : sum[PTR_W-1:0];
    assign age_valid[gi]  = (CNT_W'(gi) < count_q);
  end

  logic              found_a, full_a, found_b, full_b;
  logic [DATA_W-1:0] match_data_a, match_data_b;

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    found_a      = 1'b0;
    full_a       = 1'b0;
    match_data_a = '0;
    found_b      = 1'b0;
    full_b       = 1'b0;
    match_data_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (age_valid[i] && we_q[age_idx[i]] != '0) begin
        if (rs_a != '0 && dest_q[age_idx[i]] == rs_a) begin
          found_a      = 1'b1;
          full_a       = &we_q[age_idx[i]];
          match_data_a = data_q[age_idx[i]];
        end
        if (rs_b != '0 && dest_q[age_idx[i]] == rs_b) begin
          found_b      = 1'b1;
          full_b       = &we_q[age_idx[i]];
          match_data_b = data_q[age_idx[i]];
        end
      end
    end
  end

  assign fwd_hit_a  = found_a & full_a;
  assign fwd_hit_b  = found_b & full_b;
  assign fwd_data_a = fwd_hit_a ? match_data_a : '0;
  assign fwd_data_b = fwd_hit_b ? match_data_b : '0;
  assign wb_stall   = (found_a & ~full_a) | (found_b & ~full_b);

`ifdef WB_DEBUG_TRACE_EN
  assign debug_wb_pc       = head_pc;
  assign debug_wb_rf_we    = rf_we;
  assign debug_wb_rf_wnum  = head_dest;
  assign debug_wb_rf_wdata = head_data;
`else
  logic unused_head_pc;
  assign unused_head_pc    = ^head_pc;
  assign debug_wb_pc       = '0;
  assign debug_wb_rf_we    = '0;
  assign debug_wb_rf_wnum  = '0;
  assign debug_wb_rf_wdata = '0;
`endif

endmodule

// File: tb/tb_wb_retire_queue.sv
// Directed-vector bench for wb_retire_queue (DEPTH=2, 32-bit data); inputs change on negedge, checks 1ns later.
module tb_wb_retire_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_to_wb_valid;
  logic [31:0] mem_pc;
  logic [3:0]  mem_byte_we;
  logic [4:0]  mem_dest;
  logic [31:0] mem_result;
  logic        wb_allowin;
  logic        rf_ready;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rs_a, rs_b;
  logic        fwd_hit_a, fwd_hit_b;
  logic [31:0] fwd_data_a, fwd_data_b;
  logic        wb_stall, wb_empty;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_retire_queue #(.DATA_W(32), .REG_AW(5), .PC_W(32), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .mem_to_wb_valid(mem_to_wb_valid), .mem_pc(mem_pc), .mem_byte_we(mem_byte_we),
    .mem_dest(mem_dest), .mem_result(mem_result), .wb_allowin(wb_allowin),
    .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rs_a(rs_a), .rs_b(rs_b), .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b), .wb_stall(wb_stall), .wb_empty(wb_empty),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  // One line per retirement transaction.
  always @(posedge clk) begin
    if (!reset && rf_we != 4'h0) begin
      $display("retire waddr=%0d we=%h data=%h", rf_waddr, rf_we, rf_wdata);
    end
  end

  task automatic drive_mem(input logic v, input logic [31:0] pc, input logic [3:0] we,
                           input logic [4:0] dest, input logic [31:0] data);
    mem_to_wb_valid = v;
    mem_pc          = pc;
    mem_byte_we     = we;
    mem_dest        = dest;
    mem_result      = data;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1; rf_ready = 1'b0; rs_a = 5'd0; rs_b = 5'd0;
    drive_mem(1'b0, 32'h0, 4'h0, 5'd0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", wb_empty); end
    checks++; if (wb_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin: got %b expected 1", wb_allowin); end
    checks++; if (rf_we !== 4'h0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0) begin errors++; $display("FAIL reset_rf: got we=%h addr=%0d data=%h expected 0/0/0", rf_we, rf_waddr, rf_wdata); end
    checks++; if (debug_wb_pc !== 32'h0 || debug_wb_rf_we !== 4'h0) begin errors++; $display("FAIL reset_debug: got pc=%h we=%h expected 0/0", debug_wb_pc, debug_wb_rf_we); end
  endtask

  task automatic test_single;
    logic [3:0] exp_dbg_we;
`ifdef WB_DEBUG_TRACE_EN
    exp_dbg_we = 4'hF;
`else
    exp_dbg_we = 4'h0;
`endif
    @(negedge clk);
    rf_ready = 1'b1;
    drive_mem(1'b1, 32'hBFC00000, 4'hF, 5'd5, 32'h12345678);
    #1;
    checks++; if (wb_allowin !== 1'b1) begin errors++; $display("FAIL single_allowin: got %b expected 1", wb_allowin); end
    checks++; if (rf_we !== 4'h0) begin errors++; $display("FAIL single_no_bypass: got %h expected 0", rf_we); end
    @(negedge clk);
    drive_mem(1'b0, 32'h0, 4'h0, 5'd0, 32'h0);
    #1;
    checks++; if (rf_we !== 4'hF || rf_waddr !== 5'd5 || rf_wdata !== 32'h12345678) begin errors++; $display("FAIL single_retire: got we=%h addr=%0d data=%h expected f/5/12345678", rf_we, rf_waddr, rf_wdata); end
    checks++; if (debug_wb_rf_we !== exp_dbg_we) begin errors++; $display("FAIL single_debug_we: got %h expected %h", debug_wb_rf_we, exp_dbg_we); end
    checks++; if (wb_allowin !== 1'b1) begin errors++; $display("FAIL single_allowin2: got %b expected 1", wb_allowin); end
    @(negedge clk);
    #1;
    checks++; if (wb_empty !== 1'b1 || rf_we !== 4'h0) begin errors++; $display("FAIL single_drained: got empty=%b we=%h expected 1/0", wb_empty, rf_we); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    rf_ready = 1'b0;
    drive_mem(1'b1, 32'h100, 4'hF, 5'd1, 32'h111);
    #1;
    checks++; if (wb_allowin !== 1'b1) begin errors++; $display("FAIL b2b_allow1: got %b expected 1", wb_allowin); end
    @(negedge clk);
    drive_mem(1'b1, 32'h104, 4'hF, 5'd2, 32'h222);
    #1;
    checks++; if (wb_allowin !== 1'b1) begin errors++; $display("FAIL b2b_allow2: got %b expected 1", wb_allowin); end
    @(negedge clk);
    drive_mem(1'b1, 32'h108, 4'hF, 5'd3, 32'h333);
    #1;
    checks++; if (wb_allowin !== 1'b0) begin errors++; $display("FAIL b2b_full_allow: got %b expected 0", wb_allowin); end
    checks++; if (rf_we !== 4'h0) begin errors++; $display("FAIL b2b_stalled_we: got %h expected 0", rf_we); end
    @(negedge clk);
    rf_ready = 1'b1;
    #1;
    checks++; if (wb_allowin !== 1'b1) begin errors++; $display("FAIL b2b_full_pop_allow: got %b expected 1", wb_allowin); end
    checks++; if (rf_we !== 4'hF || rf_waddr !== 5'd1 || rf_wdata !== 32'h111) begin errors++; $display("FAIL b2b_ret1: got we=%h addr=%0d data=%h expected f/1/111", rf_we, rf_waddr, rf_wdata); end
    @(negedge clk);
    drive_mem(1'b0, 32'h0, 4'h0, 5'd0, 32'h0);
    #1;
    checks++; if (rf_we !== 4'hF || rf_waddr !== 5'd2 || rf_wdata !== 32'h222) begin errors++; $display("FAIL b2b_ret2: got we=%h addr=%0d data=%h expected f/2/222", rf_we, rf_waddr, rf_wdata); end
    @(negedge clk);
    #1;
    checks++; if (rf_we !== 4'hF || rf_waddr !== 5'd3 || rf_wdata !== 32'h333) begin errors++; $display("FAIL b2b_ret3: got we=%h addr=%0d data=%h expected f/3/333", rf_we, rf_waddr, rf_wdata); end
    @(negedge clk);
    #1;
    checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b expected 1", wb_empty); end
  endtask

  task automatic test_forward;
    @(negedge clk);
    rf_ready = 1'b0;
    drive_mem(1'b1, 32'h200, 4'hF, 5'd7, 32'hAA);
    @(negedge clk);
    drive_mem(1'b1, 32'h204, 4'hF, 5'd7, 32'hBB);
    @(negedge clk);
    drive_mem(1'b0, 32'h0, 4'h0, 5'd0, 32'h0);
    rs_a = 5'd7; rs_b = 5'd0;
    #1;
    checks++; if (fwd_hit_a !== 1'b1 || fwd_data_a !== 32'hBB) begin errors++; $display("FAIL fwd_youngest: got hit=%b data=%h expected 1/bb", fwd_hit_a, fwd_data_a); end
    checks++; if (fwd_hit_b !== 1'b0 || fwd_data_b !== 32'h0) begin errors++; $display("FAIL fwd_r0: got hit=%b data=%h expected 0/0", fwd_hit_b, fwd_data_b); end
    checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL fwd_nostall: got %b expected 0", wb_stall); end
    rs_b = 5'd8;
    #1;
    checks++; if (fwd_hit_b !== 1'b0 || fwd_data_b !== 32'h0) begin errors++; $display("FAIL fwd_miss: got hit=%b data=%h expected 0/0", fwd_hit_b, fwd_data_b); end
    @(negedge clk);
    rf_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (fwd_hit_a !== 1'b1 || fwd_data_a !== 32'hBB || rf_we !== 4'hF) begin errors++; $display("FAIL fwd_head_pop: got hit=%b data=%h we=%h expected 1/bb/f", fwd_hit_a, fwd_data_a, rf_we); end
    @(negedge clk);
    #1;
    checks++; if (fwd_hit_a !== 1'b0 || fwd_data_a !== 32'h0) begin errors++; $display("FAIL fwd_empty: got hit=%b data=%h expected 0/0", fwd_hit_a, fwd_data_a); end
    rs_a = 5'd0; rs_b = 5'd0;
  endtask

  task automatic test_partial;
    @(negedge clk);
    rf_ready = 1'b0;
    drive_mem(1'b1, 32'h300, 4'b0011, 5'd9, 32'hCAFE1234);
    @(negedge clk);
    drive_mem(1'b0, 32'h0, 4'h0, 5'd0, 32'h0);
    rs_a = 5'd9;
    #1;
    checks++; if (wb_stall !== 1'b1 || fwd_hit_a !== 1'b0) begin errors++; $display("FAIL partial_stall: got stall=%b hit=%b expected 1/0", wb_stall, fwd_hit_a); end
    rf_ready = 1'b1;
    #1;
    checks++; if (wb_stall !== 1'b1 || rf_we !== 4'b0011) begin errors++; $display("FAIL partial_pop: got stall=%b we=%h expected 1/3", wb_stall, rf_we); end
    @(negedge clk);
    #1;
    checks++; if (wb_stall !== 1'b0 || wb_empty !== 1'b1) begin errors++; $display("FAIL partial_cleared: got stall=%b empty=%b expected 0/1", wb_stall, wb_empty); end
    rs_a = 5'd0;
  endtask

  task automatic test_dest0;
    @(negedge clk);
    rf_ready = 1'b0;
    drive_mem(1'b1, 32'h400, 4'hF, 5'd0, 32'hFFFFFFFF);
    @(negedge clk);
    drive_mem(1'b0, 32'h0, 4'h0, 5'd0, 32'h0);
    rs_a = 5'd0;
    rf_ready = 1'b1;
    #1;
    checks++; if (wb_empty !== 1'b0 || rf_we !== 4'h0) begin errors++; $display("FAIL dest0_retire: got empty=%b we=%h expected 0/0", wb_empty, rf_we); end
    checks++; if (fwd_hit_a !== 1'b0 || wb_stall !== 1'b0) begin errors++; $display("FAIL dest0_fwd: got hit=%b stall=%b expected 0/0", fwd_hit_a, wb_stall); end
    @(negedge clk);
    #1;
    checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL dest0_empty: got %b expected 1", wb_empty); end
  endtask

  task automatic test_reset_mid_drain;
    @(negedge clk);
    rf_ready = 1'b0;
    drive_mem(1'b1, 32'h500, 4'hF, 5'd10, 32'hA0);
    @(negedge clk);
    drive_mem(1'b1, 32'h504, 4'hF, 5'd11, 32'hB0);
    @(negedge clk);
    drive_mem(1'b0, 32'h0, 4'h0, 5'd0, 32'h0);
    rf_ready = 1'b1;
    #1;
    checks++; if (rf_we !== 4'hF || rf_waddr !== 5'd10) begin errors++; $display("FAIL mid_first: got we=%h addr=%0d expected f/10", rf_we, rf_waddr); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (rf_waddr !== 5'd11) begin errors++; $display("FAIL mid_second_head: got %0d expected 11", rf_waddr); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (wb_empty !== 1'b1 || rf_we !== 4'h0 || rf_waddr !== 5'd0) begin errors++; $display("FAIL mid_reset: got empty=%b we=%h addr=%0d expected 1/0/0", wb_empty, rf_we, rf_waddr); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++; if (rf_we !== 4'h0 || wb_empty !== 1'b1) begin errors++; $display("FAIL mid_stale: got we=%h empty=%b expected 0/1", rf_we, wb_empty); end
    end
  endtask

  initial begin
    reset = 1'b1;
    rf_ready = 1'b0;
    rs_a = 5'd0;
    rs_b = 5'd0;
    drive_mem(1'b0, 32'h0, 4'h0, 5'd0, 32'h0);
    test_reset();
    test_single();
    test_back_to_back();
    test_forward();
    test_partial();
    test_dest0();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
